// File: rtl/wb_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_slave_regs                                                |
// | Description : WISHBONE slave register bank for the SPI core: CTRL/DIV      |
// |               registers, TX FIFO, RX holding register, status and irq.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_slave_regs #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADR_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb,
  input  logic                  we,
  input  logic [ADR_WIDTH-1:0]  adr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] div,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  irq
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0]       c_DEPTH   = c_CW'(FIFO_DEPTH);
  localparam logic [3:0]            c_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [DATA_WIDTH-1:0] c_DIV_RST = DATA_WIDTH'(1);

  localparam logic [2:0] c_A_CTRL   = 3'd0;
  localparam logic [2:0] c_A_DIV    = 3'd1;
  localparam logic [2:0] c_A_TXDATA = 3'd2;
  localparam logic [2:0] c_A_RXDATA = 3'd3;
  localparam logic [2:0] c_A_STATUS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_fire;

  logic [DATA_WIDTH-1:0] r_ctrl, r_div, r_dout, r_rx_hold;
  logic                  r_rx_full, r_tx_ovf, r_rx_ovr, r_irq;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]       r_count;

  logic [2:0]            w_sel;
  logic                  w_wr_ctrl, w_wr_div, w_push, w_wr_stat, w_rx_pop;
  logic                  w_tx_empty, w_tx_full, w_pop, w_push_ok, w_push_drop;
  logic                  w_rx_load, w_ovr_set;
  logic [DATA_WIDTH-1:0] w_status, w_rdata;
  logic                  w_unused_adr;

  assign w_sel        = adr[2:0];
  assign w_unused_adr = ^adr[ADR_WIDTH-1:3];

  // ------------------------------------------------------------------
  // Access FSM: side effects fire only on the edge that enters ACK
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (stb) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACK;
            w_fire      = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!stb) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACK;
          w_fire      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACK: begin
        if (!stb) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ack  = (r_state == S_ACK);
  assign dout = ack ? r_dout : '0;

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  assign w_wr_ctrl = w_fire &  we & (w_sel == c_A_CTRL);
  assign w_wr_div  = w_fire &  we & (w_sel == c_A_DIV);
  assign w_push    = w_fire &  we & (w_sel == c_A_TXDATA);
  assign w_wr_stat = w_fire &  we & (w_sel == c_A_STATUS);
  assign w_rx_pop  = w_fire & ~we & (w_sel == c_A_RXDATA) & r_rx_full;

  assign w_tx_empty = (r_count == '0);
  assign w_tx_full  = (r_count == c_DEPTH);

  always_comb begin
    w_status    = '0;
    w_status[0] = w_tx_empty;
    w_status[1] = w_tx_full;
    w_status[2] = r_rx_full;
    w_status[3] = r_tx_ovf;
    w_status[4] = r_rx_ovr;
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      c_A_CTRL:   w_rdata = r_ctrl;
      c_A_DIV:    w_rdata = r_div;
      c_A_RXDATA: w_rdata = r_rx_full ? r_rx_hold : '0;
      c_A_STATUS: w_rdata = w_status;
      default:    w_rdata = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // Control registers and read data
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= '0;
      r_div  <= c_DIV_RST;
      r_dout <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= din;
      if (w_wr_div)  r_div  <= (din == '0) ? c_DIV_RST : din;
      if (w_fire)    r_dout <= we ? '0 : w_rdata;
    end
  end

  assign ctrl = r_ctrl;
  assign div  = r_div;

  // ------------------------------------------------------------------
  // TX FIFO: a simultaneous pop frees the slot for a push into a full FIFO
  // ------------------------------------------------------------------
  assign w_pop       = ~w_tx_empty & tx_ready;
  assign w_push_ok   = w_push & (~w_tx_full | w_pop);
  assign w_push_drop = w_push & ~w_push_ok;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign tx_valid = ~w_tx_empty;
  assign tx_data  = w_tx_empty ? '0 : r_mem[r_rd_ptr];

  // ------------------------------------------------------------------
  // RX holding register and sticky flags (set beats write-1-clear)
  // ------------------------------------------------------------------
  assign w_rx_load = rx_valid & (~r_rx_full | w_rx_pop);
  assign w_ovr_set = rx_valid &  r_rx_full & ~w_rx_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_hold <= '0;
      r_rx_full <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_rx_load) begin
        r_rx_hold <= rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_full <= 1'b0;
      end
      r_tx_ovf <= w_push_drop | (r_tx_ovf & ~(w_wr_stat & din[3]));
      r_rx_ovr <= w_ovr_set   | (r_rx_ovr & ~(w_wr_stat & din[4]));
      r_irq    <= r_ctrl[7] & (r_rx_full | w_tx_empty | r_tx_ovf | r_rx_ovr);
    end
  end

  assign irq = r_irq;

endmodule
`default_nettype wire
